// File: rtl/inv_butterfly_if.sv
// -----------------------------------------------------------------------------
// inv_butterfly_if
// Streaming bundle for the inverse radix-2 butterfly.
//
// Handshake: a vector moves across a boundary on a rising clock edge exactly
// when valid && ready are both high. A producer holding valid high keeps its
// payload unchanged until that transfer happens. in_ready may depend
// combinationally on out_ready; valids never depend on ready.
//
// Signals (W-bit samples are Q1.(W-1) two's complement):
//   in_valid / in_ready                  input handshake
//   y_real, y_imag                       forward-butterfly sum output
//   z_real, z_imag                       forward-butterfly difference output
//   tw_real, tw_imag                     forward twiddle (not conjugated)
//   out_valid / out_ready                output handshake
//   a_real, a_imag, b_real, b_imag       recovered operands
//   sat                                  this output's b was clipped
//   sat_sticky                           OR of every delivered sat since reset
// Modports: master = upstream source / downstream sink side, slave = the block.
// -----------------------------------------------------------------------------
interface inv_butterfly_if #(
    parameter int W = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] y_real;
    logic [W-1:0] y_imag;
    logic [W-1:0] z_real;
    logic [W-1:0] z_imag;
    logic [W-1:0] tw_real;
    logic [W-1:0] tw_imag;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a_real;
    logic [W-1:0] a_imag;
    logic [W-1:0] b_real;
    logic [W-1:0] b_imag;
    logic         sat;
    logic         sat_sticky;

    modport master (
        output in_valid, y_real, y_imag, z_real, z_imag, tw_real, tw_imag,
        output out_ready,
        input  in_ready, out_valid, a_real, a_imag, b_real, b_imag,
        input  sat, sat_sticky
    );

    modport slave (
        input  in_valid, y_real, y_imag, z_real, z_imag, tw_real, tw_imag,
        input  out_ready,
        output in_ready, out_valid, a_real, a_imag, b_real, b_imag,
        output sat, sat_sticky
    );
endinterface

// File: rtl/inv_butterfly.sv
// -----------------------------------------------------------------------------
// inv_butterfly
// Pipelined inverse radix-2 butterfly. Given the forward outputs
// y = a + b*w and z = a - b*w plus the forward twiddle w, it recovers
//   a = (y + z) / 2
//   b = (y - z) / 2 * conj(w)
// Three register stages (S1 sum/diff, S2 half and complex product, S3 round
// and saturate). S3 drives the outputs. One global enable stalls every stage
// together, so latency is 3 accepted-to-valid cycles and throughput is one
// vector per cycle.
//
// Ports:
//   clk   in  rising-edge clock
//   rst   in  asynchronous active-high reset; clears every stage and flag
//   bus   inv_butterfly_if.slave (stream in, stream out, sat flags)
// -----------------------------------------------------------------------------
module inv_butterfly #(
    parameter int W = 16
) (
    input  logic            clk,
    input  logic            rst,
    inv_butterfly_if.slave  bus
);
    localparam int SW = W + 1;      // sum/difference width
    localparam int PW = 2 * W + 2;  // product-sum width
    localparam int RW = PW + 1;     // product plus rounding constant

    localparam logic signed [RW-1:0] HALF  = {{(RW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic signed [RW-1:0] B_MAX = {{(RW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [RW-1:0] B_MIN = {{(RW-W+1){1'b1}}, {(W-1){1'b0}}};

    // Global enable: the output register can take a new value whenever it is
    // empty or being drained this cycle; every earlier stage follows it.
    logic w_en;

    // S1 registers
    logic                 r1_valid;
    logic signed [SW-1:0] r1_s_re, r1_s_im, r1_d_re, r1_d_im;
    logic signed [W-1:0]  r1_tw_re, r1_tw_im;

    // S2 registers
    logic                 r2_valid;
    logic signed [W-1:0]  r2_a_re, r2_a_im;
    logic signed [PW-1:0] r2_pr, r2_pi;

    // S3 registers
    logic                 r3_valid;
    logic [W-1:0]         r3_a_re, r3_a_im, r3_b_re, r3_b_im;
    logic                 r3_sat;
    logic                 r_sat_sticky;

    assign w_en         = !r3_valid || bus.out_ready;
    assign bus.in_ready = w_en;

    // ---------------- S1: sum and difference, sign-extended ----------------
    logic signed [SW-1:0] w_s_re, w_s_im, w_d_re, w_d_im;
    assign w_s_re = {bus.y_real[W-1], bus.y_real} + {bus.z_real[W-1], bus.z_real};
    assign w_s_im = {bus.y_imag[W-1], bus.y_imag} + {bus.z_imag[W-1], bus.z_imag};
    assign w_d_re = {bus.y_real[W-1], bus.y_real} - {bus.z_real[W-1], bus.z_real};
    assign w_d_im = {bus.y_imag[W-1], bus.y_imag} - {bus.z_imag[W-1], bus.z_imag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_valid <= 1'b0;
            r1_s_re  <= '0;
            r1_s_im  <= '0;
            r1_d_re  <= '0;
            r1_d_im  <= '0;
            r1_tw_re <= '0;
            r1_tw_im <= '0;
        end else if (w_en) begin
            r1_valid <= bus.in_valid;
            r1_s_re  <= w_s_re;
            r1_s_im  <= w_s_im;
            r1_d_re  <= w_d_re;
            r1_d_im  <= w_d_im;
            r1_tw_re <= bus.tw_real;
            r1_tw_im <= bus.tw_imag;
        end
    end

    // ---------------- S2: halve s, multiply d by conj(tw) ------------------
    // (s + 1) >>> 1 rounds half up; the W+1-bit sum plus one cannot overflow
    // and the halved value always fits W bits.
    logic signed [SW-1:0] w_a_re_t, w_a_im_t;
    assign w_a_re_t = r1_s_re + SW'(1);
    assign w_a_im_t = r1_s_im + SW'(1);

    logic signed [PW-1:0] w_d_re_x, w_d_im_x, w_tw_re_x, w_tw_im_x;
    logic signed [PW-1:0] w_pr, w_pi;
    assign w_d_re_x  = PW'(r1_d_re);
    assign w_d_im_x  = PW'(r1_d_im);
    assign w_tw_re_x = PW'(r1_tw_re);
    assign w_tw_im_x = PW'(r1_tw_im);
    // d * conj(tw): real = dr*wr + di*wi, imag = di*wr - dr*wi
    assign w_pr = w_d_re_x * w_tw_re_x + w_d_im_x * w_tw_im_x;
    assign w_pi = w_d_im_x * w_tw_re_x - w_d_re_x * w_tw_im_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_valid <= 1'b0;
            r2_a_re  <= '0;
            r2_a_im  <= '0;
            r2_pr    <= '0;
            r2_pi    <= '0;
        end else if (w_en) begin
            r2_valid <= r1_valid;
            r2_a_re  <= W'(w_a_re_t >>> 1);
            r2_a_im  <= W'(w_a_im_t >>> 1);
            r2_pr    <= w_pr;
            r2_pi    <= w_pi;
        end
    end

    // ---------------- S3: round, shift by W, saturate ----------------------
    // Shifting by W rather than W-1 folds the /2 of (y-z)/2 into the Q1.(W-1)
    // renormalisation. tw = -1.0 can push the result one step past full scale;
    // that case is caught here and nowhere else.
    logic signed [RW-1:0] w_pr_rnd, w_pi_rnd, w_br_wide, w_bi_wide;
    assign w_pr_rnd  = {r2_pr[PW-1], r2_pr} + HALF;
    assign w_pi_rnd  = {r2_pi[PW-1], r2_pi} + HALF;
    assign w_br_wide = w_pr_rnd >>> W;
    assign w_bi_wide = w_pi_rnd >>> W;

    logic [W-1:0] w_br_sat, w_bi_sat;
    logic         w_sat_re, w_sat_im;

    always_comb begin
        w_br_sat = w_br_wide[W-1:0];
        w_bi_sat = w_bi_wide[W-1:0];
        w_sat_re = 1'b0;
        w_sat_im = 1'b0;
        if (w_br_wide > B_MAX) begin
            w_br_sat = B_MAX[W-1:0];
            w_sat_re = 1'b1;
        end else if (w_br_wide < B_MIN) begin
            w_br_sat = B_MIN[W-1:0];
            w_sat_re = 1'b1;
        end
        if (w_bi_wide > B_MAX) begin
            w_bi_sat = B_MAX[W-1:0];
            w_sat_im = 1'b1;
        end else if (w_bi_wide < B_MIN) begin
            w_bi_sat = B_MIN[W-1:0];
            w_sat_im = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r3_valid <= 1'b0;
            r3_a_re  <= '0;
            r3_a_im  <= '0;
            r3_b_re  <= '0;
            r3_b_im  <= '0;
            r3_sat   <= 1'b0;
        end else if (w_en) begin
            r3_valid <= r2_valid;
            r3_a_re  <= r2_a_re;
            r3_a_im  <= r2_a_im;
            r3_b_re  <= w_br_sat;
            r3_b_im  <= w_bi_sat;
            r3_sat   <= w_sat_re || w_sat_im;
        end
    end

    // Sticky flag only counts outputs that were actually delivered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sat_sticky <= 1'b0;
        end else if (r3_valid && bus.out_ready) begin
            r_sat_sticky <= r_sat_sticky || r3_sat;
        end
    end

    assign bus.out_valid  = r3_valid;
    assign bus.a_real     = r3_a_re;
    assign bus.a_imag     = r3_a_im;
    assign bus.b_real     = r3_b_re;
    assign bus.b_imag     = r3_b_im;
    assign bus.sat        = r3_sat;
    assign bus.sat_sticky = r_sat_sticky;
endmodule
